// File: rtl/vrased_rst_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vrased_rst_pkg : shared encodings for the VRASED reset sequencer
// rev 1.0
// ----------------------------------------------------------------------------
package vrased_rst_pkg;

    localparam int unsigned NUM_VIOL = 6;

    localparam int unsigned VIOL_XSTACK     = 0;
    localparam int unsigned VIOL_AC         = 1;
    localparam int unsigned VIOL_ATOMICITY  = 2;
    localparam int unsigned VIOL_DMA_AC     = 3;
    localparam int unsigned VIOL_DMA_DETECT = 4;
    localparam int unsigned VIOL_DMA_XSTACK = 5;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] WAIT_PC = 2'd2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? 8'hFF : val + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vrased_hold_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vrased_hold_timer : 8-bit loadable down/up counter with zero/match flags
// rev 1.0
// ----------------------------------------------------------------------------
module vrased_hold_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] match_val_i,
    output logic             zero_o,
    output logic             match_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // load wins over dec, dec over inc
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i) begin
            count_d = count_q - 1'b1;
        end else if (inc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o  = (count_q == '0);
    assign match_o = (count_q == match_val_i);

endmodule
`default_nettype wire

// File: rtl/vrased_rst_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vrased_rst_seq : turns VRASED monitor violations into a stretched core reset
//                  and keeps cause/count status for attestation
// rev 1.0
// ----------------------------------------------------------------------------
module vrased_rst_seq
    import vrased_rst_pkg::*;
#(
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter int unsigned BOOT_TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_VIOL-1:0] viol,
    input  logic [15:0]         pc,
    output logic                core_rst,
    output logic                busy,
    output logic [NUM_VIOL-1:0] first_cause,
    output logic [NUM_VIOL-1:0] sticky_cause,
    output logic [7:0]          viol_cnt
);

    localparam logic [7:0] c_hold_load  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] c_boot_limit = 8'(BOOT_TIMEOUT - 1);

    logic [1:0]          state_q,    state_d;
    logic                core_rst_q, core_rst_d;
    logic                busy_q,     busy_d;
    logic [NUM_VIOL-1:0] first_q,    first_d;
    logic [NUM_VIOL-1:0] sticky_q,   sticky_d;
    logic [7:0]          cnt_q,      cnt_d;

    logic       w_any_v;
    logic       w_t_load;
    logic [7:0] w_t_load_val;
    logic       w_t_dec;
    logic       w_t_inc;
    logic       w_t_zero;
    logic       w_t_match;

    assign w_any_v = |viol;

    vrased_hold_timer #(
        .WIDTH (8)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .load_i      (w_t_load),
        .load_val_i  (w_t_load_val),
        .dec_i       (w_t_dec),
        .inc_i       (w_t_inc),
        .match_val_i (c_boot_limit),
        .zero_o      (w_t_zero),
        .match_o     (w_t_match)
    );

    always_comb begin
        state_d      = state_q;
        core_rst_d   = 1'b0;
        first_d      = first_q;
        sticky_d     = sticky_q | viol;
        cnt_d        = cnt_q;
        w_t_load     = 1'b0;
        w_t_load_val = 8'd0;
        w_t_dec      = 1'b0;
        w_t_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_any_v) begin
                    state_d      = HOLD;
                    core_rst_d   = 1'b1;
                    first_d      = viol;
                    cnt_d        = sat_inc8(cnt_q);
                    w_t_load     = 1'b1;
                    w_t_load_val = c_hold_load;
                end
            end
            // Violations here are not episodes: the monitors see a stale pc
            // while the core is held.
            HOLD: begin
                if (w_t_zero) begin
                    state_d      = WAIT_PC;
                    w_t_load     = 1'b1;
                    w_t_load_val = 8'd0;
                end else begin
                    core_rst_d = 1'b1;
                    w_t_dec    = 1'b1;
                end
            end
            WAIT_PC: begin
                if (w_any_v) begin
                    state_d      = HOLD;
                    core_rst_d   = 1'b1;
                    first_d      = viol;
                    cnt_d        = sat_inc8(cnt_q);
                    w_t_load     = 1'b1;
                    w_t_load_val = c_hold_load;
                end else if (pc == RESET_HANDLER) begin
                    state_d = IDLE;
                end else if (w_t_match) begin
                    // Re-issue of the same episode: cause and count untouched.
                    state_d      = HOLD;
                    core_rst_d   = 1'b1;
                    w_t_load     = 1'b1;
                    w_t_load_val = c_hold_load;
                end else begin
                    w_t_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            core_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            first_q    <= '0;
            sticky_q   <= '0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            first_q    <= first_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign core_rst     = core_rst_q;
    assign busy         = busy_q;
    assign first_cause  = first_q;
    assign sticky_cause = sticky_q;
    assign viol_cnt     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vrased_rst_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vrased_rst_seq : scenario testbench for the VRASED reset sequencer
// rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vrased_rst_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  viol;
    logic [15:0] pc;
    logic        core_rst;
    logic        busy;
    logic [5:0]  first_cause;
    logic [5:0]  sticky_cause;
    logic [7:0]  viol_cnt;

    vrased_rst_seq #(
        .RESET_HANDLER (16'h0000),
        .HOLD_CYCLES   (8),
        .BOOT_TIMEOUT  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .viol         (viol),
        .pc           (pc),
        .core_rst     (core_rst),
        .busy         (busy),
        .first_cause  (first_cause),
        .sticky_cause (sticky_cause),
        .viol_cnt     (viol_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       core_rst;
        logic       busy;
        logic [5:0] first;
        logic [5:0] sticky;
        logic [7:0] cnt;
    } obs_t;

    obs_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [5:0]  m_first;
    logic [5:0]  m_sticky;
    int          m_cnt;

    localparam logic [15:0] PC_APP = 16'hE000;

    function automatic obs_t expect_obs(input logic cr, input logic b);
        obs_t o;
        logic [7:0] c;
        c = (m_cnt > 255) ? 8'hFF : 8'(m_cnt);
        o = {cr, b, m_first, m_sticky, c};
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = {core_rst, busy, first_cause, sticky_cause, viol_cnt};
        return o;
    endfunction

    task automatic tick(input logic r, input logic [5:0] v, input logic [15:0] p);
        reset = r;
        viol  = v;
        pc    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(1'b1, 6'b0, PC_APP);
        tick(1'b1, 6'b0, PC_APP);
        m_first = '0; m_sticky = '0; m_cnt = 0;
    endtask

    task automatic test_reset();
        obs_t got, e;
        m_first = '0; m_sticky = '0; m_cnt = 0;
        for (int j = 1; j <= 23; j++) begin
            exp_q.push_back(expect_obs(1'b0, 1'b0));
            tick(j <= 3, 6'b0, PC_APP);
            got = sample(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", j, got, e);
            end
        end
    endtask

    // violation 000010 at t, pc reaches the handler at t+12
    task automatic test_single();
        obs_t got, e;
        logic [5:0] v;
        for (int j = 1; j <= 14; j++) begin
            v = (j == 1) ? 6'b000010 : 6'b0;
            m_sticky |= v;
            if (j == 1) begin m_first = v; m_cnt++; end
            exp_q.push_back(expect_obs(j <= 8, j <= 12));
            tick(1'b0, v, (j == 13) ? 16'h0000 : PC_APP);
            got = sample(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL single cyc=%0d got=%h exp=%h", j, got, e);
            end
        end
    endtask

    task automatic test_multi();
        obs_t got, e;
        logic [5:0] v;
        for (int j = 1; j <= 10; j++) begin
            v = (j == 1) ? 6'b100100 : (j == 4) ? 6'b000001 : 6'b0;
            m_sticky |= v;
            if (j == 1) begin m_first = v; m_cnt++; end
            exp_q.push_back(expect_obs(j <= 8, j <= 9));
            tick(1'b0, v, (j == 10) ? 16'h0000 : PC_APP);
            got = sample(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL multi cyc=%0d got=%h exp=%h", j, got, e);
            end
        end
        checks++;
        if (sticky_cause !== 6'b100101) begin
            errors++;
            $display("FAIL multi_sticky got=%b exp=%b", sticky_cause, 6'b100101);
        end
    endtask

    // 8 hold cycles, 16 wait cycles, then an 8-cycle re-issue
    task automatic test_timeout();
        obs_t got, e;
        logic [5:0] v;
        for (int j = 1; j <= 34; j++) begin
            v = (j == 1) ? 6'b001000 : 6'b0;
            m_sticky |= v;
            if (j == 1) begin m_first = v; m_cnt++; end
            exp_q.push_back(expect_obs((j <= 8) || (j >= 25 && j <= 32), j <= 33));
            tick(1'b0, v, (j == 34) ? 16'h0000 : PC_APP);
            got = sample(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL timeout cyc=%0d got=%h exp=%h", j, got, e);
            end
        end
    endtask

    task automatic test_wait_viol();
        obs_t got, e;
        logic [5:0] v;
        for (int j = 1; j <= 20; j++) begin
            v = (j == 1) ? 6'b000001 : (j == 11) ? 6'b010000 : 6'b0;
            m_sticky |= v;
            if (j == 1 || j == 11) begin m_first = v; m_cnt++; end
            exp_q.push_back(expect_obs((j <= 8) || (j >= 11 && j <= 18), j <= 19));
            tick(1'b0, v, (j == 20) ? 16'h0000 : PC_APP);
            got = sample(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL wait_viol cyc=%0d got=%h exp=%h", j, got, e);
            end
        end
    endtask

    // back-to-back episodes, each re-triggered from WAIT_PC
    task automatic test_saturation();
        obs_t got, e;
        m_first = 6'b100000;
        m_sticky |= 6'b100000;
        for (int ep = 0; ep < 300; ep++) begin
            for (int k = 0; k <= 8; k++) begin
                if (k == 0) m_cnt++;
                exp_q.push_back(expect_obs(k <= 7, 1'b1));
                tick(1'b0, (k == 0) ? 6'b100000 : 6'b0, PC_APP);
                got = sample(); e = exp_q.pop_front(); checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL saturate ep=%0d k=%0d got=%h exp=%h", ep, k, got, e);
                end
            end
        end
        exp_q.push_back(expect_obs(1'b0, 1'b0));
        tick(1'b0, 6'b0, 16'h0000);
        got = sample(); e = exp_q.pop_front(); checks++;
        if (got !== e || viol_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL saturate_end got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_reset_mid_hold();
        obs_t got, e;
        logic [5:0] v;
        logic       r;
        for (int j = 1; j <= 8; j++) begin
            r = (j == 5);
            v = (j == 1) ? 6'b000100 : (j == 5) ? 6'b111111 : 6'b0;
            if (j == 1) begin m_sticky |= v; m_first = v; m_cnt++; end
            if (j == 5) begin m_first = '0; m_sticky = '0; m_cnt = 0; end
            exp_q.push_back(expect_obs(j <= 4, j <= 4));
            tick(r, v, PC_APP);
            got = sample(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid_hold cyc=%0d got=%h exp=%h", j, got, e);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        viol  = 6'b0;
        pc    = PC_APP;
        test_reset();
        test_single();
        do_reset();
        test_multi();
        test_timeout();
        test_wait_viol();
        test_saturation();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
